// File: rtl/rw_ram_controller.sv
// Valid/ready initiator sequencing the clockless separate read/write-strobe RAM.
// Optional write read-back check when RW_RAM_CTRL_VERIFY_EN is defined.
module rw_ram_controller #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_datain,
    output logic              ram_read,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_dataout
);
    localparam int SET_N   = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
    localparam int STB_N   = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
    localparam int CNT_MAX = (SET_N + 1 > STB_N) ? SET_N + 1 : STB_N;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, SAMPLE, VERIFY} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             we_q, we_nxt;
    logic             accept, done, capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            we_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            we_q  <= we_nxt;
        end
    end

    // Counter is loaded with (cycles - 1) on entry; the state exits when it reaches zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        we_nxt    = we_q;
        accept    = 1'b0;
        done      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept    = 1'b1;
                    we_nxt    = req_we;
                    state_nxt = SETUP;
                    cnt_nxt   = CNT_W'(SET_N - 1);
                end
            end
            SETUP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else if (we_q) begin
                    state_nxt = STROBE;
                    cnt_nxt   = CNT_W'(STB_N - 1);
                end else begin
                    state_nxt = SAMPLE;
                end
            end
            STROBE: begin
                if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
                else           state_nxt = HOLD;
            end
            HOLD: begin
`ifdef RW_RAM_CTRL_VERIFY_EN
                state_nxt = VERIFY;
                cnt_nxt   = CNT_W'(SET_N);
`else
                state_nxt = IDLE;
                done      = 1'b1;
`endif
            end
            SAMPLE: begin
                state_nxt = IDLE;
                done      = 1'b1;
                capture   = 1'b1;
            end
`ifdef RW_RAM_CTRL_VERIFY_EN
            VERIFY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                    capture   = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Pins are decoded from the next state so every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            ram_addr   <= '0;
            ram_datain <= '0;
            ram_read   <= 1'b0;
            ram_write  <= 1'b0;
        end else begin
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= done;
            ram_write <= (state_nxt == STROBE);
            ram_read  <= ((state_nxt == SETUP) && !we_nxt) || (state_nxt == SAMPLE) ||
                         (state_nxt == VERIFY);
            if (accept) begin
                ram_addr <= req_addr;
                if (req_we) ram_datain <= req_wdata;
            end
            if (capture) rsp_rdata <= ram_dataout;
        end
    end

`ifdef RW_RAM_CTRL_VERIFY_EN
    // ram_datain still carries the written word, so it doubles as the compare reference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       rsp_err <= 1'b0;
        else if (done) rsp_err <= capture && we_q && (ram_dataout != ram_datain);
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_rw_ram_controller.sv
// Randomized bench for rw_ram_controller: default instance plus a SETUP_CYC=3/STROBE_CYC=2 instance.
// Each instance drives its own behavioural RAM; expectations come from a reference memory array.
module tb_rw_ram_controller;
`ifdef RW_RAM_CTRL_VERIFY_EN
    localparam bit VER = 1'b1;
    localparam logic [3:0] MASK = 4'hE;
`else
    localparam bit VER = 1'b0;
    localparam logic [3:0] MASK = 4'hF;
`endif

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic req_valid, req_we;
    logic [3:0] req_addr, req_wdata;

    logic       rdy0, rv0, err0, rd0, wr0;
    logic [3:0] rdata0, a0, di0, do0;
    logic       rdy1, rv1, err1, rd1, wr1;
    logic [3:0] rdata1, a1, di1, do1;

    logic [3:0] ram_mem [2][16];
    logic [3:0] ref_mem [2][16];
    logic [3:0] last_rd [2];
    int strb [2];
    int n_chk = 0, n_pass = 0, last_wait = 0;

    always #5 clk = ~clk;

    rw_ram_controller dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid && !sel), .req_ready(rdy0),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rdata0), .rsp_err(err0),
        .ram_addr(a0), .ram_datain(di0), .ram_read(rd0), .ram_write(wr0), .ram_dataout(do0)
    );

    rw_ram_controller #(.SETUP_CYC(3), .STROBE_CYC(2)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid && sel), .req_ready(rdy1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rdata1), .rsp_err(err1),
        .ram_addr(a1), .ram_datain(di1), .ram_read(rd1), .ram_write(wr1), .ram_dataout(do1)
    );

    // Behavioural RAMs: write on the rising strobe, data visible only while read is high.
    always @(posedge wr0) begin ram_mem[0][a0] = di0; strb[0]++; end
    always @(posedge wr1) begin ram_mem[1][a1] = di1; strb[1]++; end
    assign do0 = rd0 ? (ram_mem[0][a0] & MASK) : 4'h0;
    assign do1 = rd1 ? (ram_mem[1][a1] & MASK) : 4'h0;

    logic       m_ready, m_rv, m_err, m_read, m_write;
    logic [3:0] m_rdata, m_addr, m_datain;
    assign m_ready  = sel ? rdy1   : rdy0;
    assign m_rv     = sel ? rv1    : rv0;
    assign m_err    = sel ? err1   : err0;
    assign m_read   = sel ? rd1    : rd0;
    assign m_write  = sel ? wr1    : wr0;
    assign m_rdata  = sel ? rdata1 : rdata0;
    assign m_addr   = sel ? a1     : a0;
    assign m_datain = sel ? di1    : di0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    // One request on instance s; returns at the negedge of the rsp_valid cycle.
    task automatic do_op(input bit s, input bit we, input logic [3:0] a, input logic [3:0] d,
                         input bit keep);
        int s_n, t_n, exp_lat, exp_rd, lat, n_wr, n_rd, pre, rdy_early, bad, wait_c;
        bit seen_wr, done;
        logic [3:0] exp_rdata;
        logic exp_err;
        s_n = s ? 3 : 1;
        t_n = s ? 2 : 1;
        sel = s; req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
        wait_c = 0;
        while (!m_ready && wait_c < 200) begin @(negedge clk); wait_c++; end
        check("accept_wait", wait_c < 200, 1);
        last_wait = wait_c;
        @(posedge clk);
        #1;
        req_valid = keep;
        req_we = 1'($urandom); req_addr = 4'($urandom); req_wdata = 4'($urandom);
        if (we) begin
            ref_mem[s][a] = d;
            exp_lat   = s_n + t_n + 2 + (VER ? s_n + 1 : 0);
            exp_rd    = VER ? s_n + 1 : 0;
            exp_rdata = VER ? (d & MASK) : last_rd[s];
            exp_err   = VER && ((d & MASK) != d);
        end else begin
            exp_lat   = s_n + 2;
            exp_rd    = s_n + 1;
            exp_rdata = ref_mem[s][a] & MASK;
            exp_err   = 1'b0;
        end
        last_rd[s] = exp_rdata;
        lat = 0; n_wr = 0; n_rd = 0; pre = 0; rdy_early = 0; bad = 0;
        seen_wr = 1'b0; done = 1'b0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
            if (m_rv) done = 1'b1;
            else begin
                if (m_write) begin n_wr++; seen_wr = 1'b1; end
                else if (!seen_wr) pre++;
                if (m_read) n_rd++;
                if (m_ready) rdy_early++;
                if (m_addr !== a || (we && m_datain !== d)) bad++;
            end
        end
        check("rsp_seen", done, 1);
        check("latency", lat, exp_lat);
        if (we) check("setup_cycles", pre, s_n);
        check("strobe_cycles", n_wr, we ? t_n : 0);
        check("read_cycles", n_rd, exp_rd);
        check("ready_low", rdy_early, 0);
        check("pins_stable", bad, 0);
        check("rsp_rdata", m_rdata, exp_rdata);
        check("rsp_err", m_err, exp_err);
        check("ready_at_rsp", m_ready, 1);
        check("pins_idle", {m_read, m_write}, 0);
    endtask

    initial begin
        int w, spur, sb, sw;
        for (int i = 0; i < 16; i++) begin
            ram_mem[0][i] = 4'h0; ram_mem[1][i] = 4'h0;
            ref_mem[0][i] = 4'h0; ref_mem[1][i] = 4'h0;
        end
        last_rd[0] = 4'h0; last_rd[1] = 4'h0;
        strb[0] = 0; strb[1] = 0;
        rst = 1'b1; sel = 1'b0; req_valid = 1'b1; req_we = 1'b1;
        req_addr = 4'h3; req_wdata = 4'h9;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            sel = 1'(i);
            #1;
            check("rst_ready", m_ready, 1);
            check("rst_outputs", {m_rv, m_err, m_read, m_write, m_rdata, m_addr, m_datain}, 0);
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        do_op(0, 1, 4'h5, 4'hA, 0);
        check("first_edge_accept", last_wait, 0);
        check("ram_holds_A", ram_mem[0][5], 4'hA);
        do_op(0, 0, 4'h5, 4'h0, 0);

        sb = strb[0];
        do_op(0, 1, 4'h3, 4'h7, 1);
        do_op(0, 0, 4'h3, 4'h0, 1);
        do_op(0, 1, 4'h3, 4'h1, 1);
        do_op(0, 0, 4'h3, 4'h0, 0);
        check("b2b_strobes", strb[0] - sb, 2);

        do_op(0, 1, 4'h2, 4'hF, 0);
        do_op(0, 1, 4'h6, 4'h4, 0);
        do_op(0, 1, 4'h0, 4'h0, 0);
        do_op(0, 1, 4'hF, 4'h5, 0);
        do_op(0, 0, 4'hF, 4'h0, 0);
        do_op(0, 0, 4'h0, 4'h0, 0);

        repeat (60) do_op(0, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        req_valid = 1'b0;

        do_op(1, 1, 4'h9, 4'hC, 0);
        do_op(1, 0, 4'h9, 4'h0, 0);

        // Abort in STROBE: the rising strobe already wrote the RAM.
        sel = 1'b1; req_we = 1'b1; req_addr = 4'hB; req_wdata = 4'h6; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        w = 0;
        while (!m_write && w < 50) begin @(negedge clk); w++; end
        check("strobe_reached", m_write, 1);
        #2 rst = 1'b1;
        #1 check("strobe_async_drop", m_write, 0);
        ref_mem[1][4'hB] = 4'h6;
        last_rd[0] = 4'h0; last_rd[1] = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        spur = 0;
        repeat (10) begin @(negedge clk); if (m_rv) spur++; end
        check("no_rsp_after_abort", spur, 0);

        // Abort in SETUP: no strobe may ever appear.
        sb = strb[1];
        req_we = 1'b1; req_addr = 4'h0; req_wdata = 4'h3; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        spur = 0; sw = 0;
        repeat (10) begin @(negedge clk); if (m_rv) spur++; if (m_write) sw++; end
        check("setup_abort_rsp", spur, 0);
        check("setup_abort_strobe", (strb[1] - sb) + sw, 0);

        do_op(1, 0, 4'hB, 4'h0, 0);
        do_op(1, 0, 4'h0, 4'h0, 0);
        repeat (12) do_op(1, 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
